// File: rtl/sik_thread_scheduler.sv
// Two-thread fetch scheduler for the SIK stack pipeline: alternates
// fetches between live threads, bypasses redirects, flags wrong-path fetches.
module sik_thread_scheduler #(
   parameter logic [15:0] RESET_PC0 = 16'h0000,
   parameter logic [15:0] RESET_PC1 = 16'h8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic        redirect_tid,
   input  logic [15:0] redirect_pc,
   input  logic        halt_req,
   input  logic        halt_tid,
   output logic        issue_valid,
   output logic        issue_tid,
   output logic [15:0] issue_pc,
   output logic        squash,
   output logic [1:0]  thread_halted,
   output logic        halt
);

   logic [15:0] pc [2];
   logic [15:0] pc_nxt [2];
   logic        last_tid;
   logic        last_valid;
   logic [1:0]  halted;
   logic [1:0]  halting;
   logic [1:0]  live;
   logic        sel;
   logic        any_live;
   logic        fire;

   always_comb begin
      halting = 2'b00;
      if (halt_req) halting[halt_tid] = 1'b1;
      live = ~halted & ~halting;
   end

   // Prefer the thread that did not fetch last; fall back to the same one.
   always_comb begin
      sel      = ~last_tid;
      any_live = 1'b0;
      if (live[~last_tid]) begin
         sel      = ~last_tid;
         any_live = 1'b1;
      end else if (live[last_tid]) begin
         sel      = last_tid;
         any_live = 1'b1;
      end
   end

   assign fire        = reset & ~stall & any_live;
   assign issue_valid = fire;
   assign issue_tid   = sel;
   assign issue_pc    = (redirect_valid && redirect_tid == sel)
                        ? redirect_pc : pc[sel];

   assign squash = reset & redirect_valid & last_valid
                 & (last_tid == redirect_tid) & ~halted[redirect_tid];

   assign thread_halted = halted;
   assign halt          = &halted;

   always_comb begin
      for (int t = 0; t < 2; t++) begin
         pc_nxt[t] = pc[t];
         if (live[t]) begin
            if (fire && sel == 1'(t))
               pc_nxt[t] = issue_pc + 16'd1;
            else if (redirect_valid && redirect_tid == 1'(t))
               pc_nxt[t] = redirect_pc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc[0]      <= RESET_PC0;
         pc[1]      <= RESET_PC1;
         last_tid   <= 1'b1;
         last_valid <= 1'b0;
         halted     <= 2'b00;
      end else begin
         pc[0]      <= pc_nxt[0];
         pc[1]      <= pc_nxt[1];
         last_valid <= fire;
         if (fire) last_tid <= sel;
         halted     <= halted | halting;
      end
   end

endmodule

// File: tb/tb_sik_thread_scheduler.sv
// Bench for sik_thread_scheduler: directed scenarios plus random traffic,
// all outputs compared each cycle against a behavioural model.
module tb_sik_thread_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic        redirect_tid;
   logic [15:0] redirect_pc;
   logic        halt_req;
   logic        halt_tid;
   logic        issue_valid;
   logic        issue_tid;
   logic [15:0] issue_pc;
   logic        squash;
   logic [1:0]  thread_halted;
   logic        halt;

   sik_thread_scheduler dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_tid   (redirect_tid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .halt_tid       (halt_tid),
      .issue_valid    (issue_valid),
      .issue_tid      (issue_tid),
      .issue_pc       (issue_pc),
      .squash         (squash),
      .thread_halted  (thread_halted),
      .halt           (halt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: per-thread PC table, who fetched last, whether a fetch
   // happened last cycle, and which threads have executed sys.
   logic [15:0] m_pc [2];
   int          m_last;
   bit          m_lastv;
   bit          m_hlt [2];

   // Observed outputs of the most recent cycle, for literal checks.
   logic        o_v;
   logic        o_t;
   logic [15:0] o_pc;
   logic        o_sq;

   function automatic void model_reset();
      m_pc[0] = 16'h0000;
      m_pc[1] = 16'h8000;
      m_last  = 1;
      m_lastv = 0;
      m_hlt[0] = 0;
      m_hlt[1] = 0;
   endfunction

   task automatic cycle(input bit st, input bit rv, input bit rt,
                        input logic [15:0] rp, input bit hr, input bit ht);
      bit   lv [2];
      int   s;
      bit   ok;
      bit   ev;
      bit   esq;
      logic [15:0] epc;
      stall = st; redirect_valid = rv; redirect_tid = rt;
      redirect_pc = rp; halt_req = hr; halt_tid = ht;
      @(negedge clk);
      for (int t = 0; t < 2; t++)
         lv[t] = !m_hlt[t] && !(hr && int'(ht) == t);
      ok = 0;
      s  = 0;
      if (lv[1 - m_last]) begin s = 1 - m_last; ok = 1; end
      else if (lv[m_last]) begin s = m_last; ok = 1; end
      ev  = !st && ok;
      epc = (rv && int'(rt) == s) ? rp : m_pc[s];
      esq = rv && m_lastv && m_last == int'(rt) && !m_hlt[rt];
      chk("issue_valid", 32'(issue_valid), 32'(ev));
      if (ok) begin
         chk("issue_tid", 32'(issue_tid), 32'(s));
         chk("issue_pc", 32'(issue_pc), 32'(epc));
      end
      chk("squash", 32'(squash), 32'(esq));
      chk("thread_halted", 32'(thread_halted),
          32'({m_hlt[1], m_hlt[0]}));
      chk("halt", 32'(halt), 32'(m_hlt[0] && m_hlt[1]));
      o_v = issue_valid; o_t = issue_tid; o_pc = issue_pc; o_sq = squash;
      for (int t = 0; t < 2; t++) begin
         if (!lv[t]) continue;
         if (ev && s == t) m_pc[t] = epc + 16'd1;
         else if (rv && int'(rt) == t) m_pc[t] = rp;
      end
      if (ev) m_last = s;
      m_lastv = ev;
      if (hr) m_hlt[ht] = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(0, 0, 0, 16'h0, 0, 0);
   endtask

   task automatic issue_is(input string tag, input bit t,
                           input logic [15:0] p);
      chk({tag, "_v"}, 32'(o_v), 32'd1);
      chk({tag, "_tid"}, 32'(o_t), 32'(t));
      chk({tag, "_pc"}, 32'(o_pc), 32'(p));
   endtask

   // Assert reset between edges and verify outputs drop without a clock.
   task automatic async_reset();
      #2;
      reset = 1'b0;
      #1;
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_squash", 32'(squash), 32'd0);
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_thread_halted", 32'(thread_halted), 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; stall = 0; redirect_valid = 0; redirect_tid = 0;
      redirect_pc = 0; halt_req = 0; halt_tid = 0;
      model_reset();
      #3;
      chk("init_issue_valid", 32'(issue_valid), 32'd0);
      chk("init_halt", 32'(halt), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Plain alternation from reset.
      idle(); issue_is("a0", 0, 16'h0000);
      idle(); issue_is("a1", 1, 16'h8000);
      idle(); issue_is("a2", 0, 16'h0001);
      idle(); issue_is("a3", 1, 16'h8001);
      chk("a_squash", 32'(o_sq), 32'd0);

      // Stall holds pointer and PCs.
      async_reset();
      idle(); issue_is("b0", 0, 16'h0000);
      cycle(1, 0, 0, 16'h0, 0, 0); chk("b_stall1", 32'(o_v), 32'd0);
      cycle(1, 0, 0, 16'h0, 0, 0); chk("b_stall2", 32'(o_v), 32'd0);
      idle(); issue_is("b1", 1, 16'h8000);
      idle(); issue_is("b2", 0, 16'h0001);

      // Same-cycle redirect bypass.
      async_reset();
      idle();
      cycle(0, 1, 1, 16'h0123, 0, 0);
      issue_is("c0", 1, 16'h0123);
      chk("c_squash", 32'(o_sq), 32'd0);
      idle();
      idle(); issue_is("c1", 1, 16'h0124);

      // Halt T0, then squash on T1 redirect; T1 runs alone.
      async_reset();
      cycle(0, 0, 0, 16'h0, 1, 0); issue_is("d0", 1, 16'h8000);
      cycle(0, 1, 1, 16'h0200, 0, 0);
      chk("d_squash", 32'(o_sq), 32'd1);
      issue_is("d1", 1, 16'h0200);
      chk("d_halted", 32'(thread_halted), 32'd1);
      idle(); issue_is("d2", 1, 16'h0201);
      idle(); issue_is("d3", 1, 16'h0202);

      // T1 halts with a simultaneous redirect: halt wins.
      cycle(0, 1, 1, 16'h0300, 1, 1);
      chk("e_noissue", 32'(o_v), 32'd0);
      idle();
      chk("e_halt", 32'(halt), 32'd1);
      chk("e_noissue2", 32'(o_v), 32'd0);

      // PC wrap at FFFF.
      async_reset();
      cycle(0, 1, 0, 16'hFFFF, 0, 0); issue_is("f0", 0, 16'hFFFF);
      idle();
      idle(); issue_is("f1", 0, 16'h0000);
      async_reset();
      idle(); issue_is("f2", 0, 16'h0000);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] rp;
         rp = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               1'($urandom), rp, $urandom_range(0, 39) == 0,
               1'($urandom));
         if ((m_hlt[0] && m_hlt[1] && $urandom_range(0, 3) == 0)
             || $urandom_range(0, 299) == 0)
            async_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
